// File: rtl/regfile_dbg_arbiter_pkg.sv
// Shared encodings for the register-bank debug arbiter: FSM state codes,
// the hard-wired zero register index and a state-ownership helper.
package regfile_dbg_arbiter_pkg;

    localparam logic [2:0] DBG_ST_RUN      = 3'd0;
    localparam logic [2:0] DBG_ST_DRAIN    = 3'd1;
    localparam logic [2:0] DBG_ST_HALTED   = 3'd2;
    localparam logic [2:0] DBG_ST_ACCESS   = 3'd3;
    localparam logic [2:0] DBG_ST_ACK      = 3'd4;
    localparam logic [2:0] DBG_ST_WAIT_LOW = 3'd5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True in every state where the host, not the pipeline, owns the bank.
    function automatic logic dbg_owns_bank(input logic [2:0] st);
        return (st == DBG_ST_HALTED) || (st == DBG_ST_ACCESS) ||
               (st == DBG_ST_ACK)    || (st == DBG_ST_WAIT_LOW);
    endfunction

endpackage

// File: rtl/regfile_dbg_arbiter.sv
// Hands the register bank ports to a debug host after halting and draining the pipeline.
// Host writes exist only when DBG_REGFILE_WRITE_EN is defined; otherwise every access is a read.
module regfile_dbg_arbiter
    import regfile_dbg_arbiter_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_dbg_halt_req,
    input  logic        i_dbg_resume,
    input  logic        i_dbg_req,
    input  logic        i_dbg_we,
    input  logic [4:0]  i_dbg_addr,
    input  logic [31:0] i_dbg_wdata,
    output logic        o_dbg_ack,
    output logic [31:0] o_dbg_rdata,
    output logic        o_dbg_halted,
    output logic        o_dbg_wb_conflict,
    output logic        o_pipe_stall,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_wb_reg_write,
    input  logic [4:0]  i_wb_write_register,
    input  logic [31:0] i_wb_write_data,
    output logic [4:0]  o_rf_read_register_1,
    output logic [4:0]  o_rf_read_register_2,
    output logic        o_rf_write_enable,
    output logic [4:0]  o_rf_write_register,
    output logic [31:0] o_rf_write_data,
    input  logic [31:0] i_rf_read_data_1
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

`ifdef DBG_REGFILE_WRITE_EN
    localparam logic HOST_WRITE_EN = 1'b1;
`else
    localparam logic HOST_WRITE_EN = 1'b0;
`endif

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [4:0]       r_addr;
    logic             r_we;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_stall;
    logic             r_halted;
    logic             r_conflict;
    logic             w_owns;
    logic             w_dbg_we;
    logic             w_host_write;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            DBG_ST_RUN: begin
                if (i_dbg_halt_req) begin
                    w_state_next = DBG_ST_DRAIN;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            DBG_ST_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_next = DBG_ST_HALTED;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            DBG_ST_HALTED: begin
                if (i_dbg_req) begin
                    w_state_next = DBG_ST_ACCESS;
                end else if (i_dbg_resume && !i_dbg_halt_req) begin
                    w_state_next = DBG_ST_RUN;
                end
            end
            DBG_ST_ACCESS:   w_state_next = DBG_ST_ACK;
            DBG_ST_ACK:      w_state_next = DBG_ST_WAIT_LOW;
            DBG_ST_WAIT_LOW: begin
                if (!i_dbg_req) begin
                    w_state_next = DBG_ST_HALTED;
                end
            end
            default:         w_state_next = DBG_ST_RUN;
        endcase
    end

    assign w_owns       = dbg_owns_bank(r_state);
    assign w_dbg_we     = r_we & HOST_WRITE_EN;
    assign w_host_write = (r_state == DBG_ST_ACCESS) && w_dbg_we && (r_addr != REG_ZERO);

    // Enable is gated by reset so an aborted access can never commit at the reset edge.
    assign o_rf_read_register_1 = w_owns ? r_addr : i_id_rs;
    assign o_rf_read_register_2 = i_id_rt;
    assign o_rf_write_enable    = reset && (w_owns ? w_host_write : i_wb_reg_write);
    assign o_rf_write_register  = w_owns ? r_addr  : i_wb_write_register;
    assign o_rf_write_data      = w_owns ? r_wdata : i_wb_write_data;

    assign o_dbg_ack         = (r_state == DBG_ST_ACK);
    assign o_dbg_rdata       = r_rdata;
    assign o_dbg_halted      = r_halted;
    assign o_dbg_wb_conflict = r_conflict;
    assign o_pipe_stall      = r_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= DBG_ST_RUN;
            r_cnt      <= '0;
            r_addr     <= REG_ZERO;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_stall    <= 1'b0;
            r_halted   <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_stall  <= (w_state_next != DBG_ST_RUN);
            r_halted <= dbg_owns_bank(w_state_next);
            if (r_state == DBG_ST_HALTED && i_dbg_req) begin
                r_addr  <= i_dbg_addr;
                r_we    <= i_dbg_we;
                r_wdata <= i_dbg_wdata;
            end
            if (r_state == DBG_ST_ACCESS && !w_dbg_we) begin
                r_rdata <= i_rf_read_data_1;
            end
            if (w_owns && i_wb_reg_write) begin
                r_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Directed plus randomized bench for regfile_dbg_arbiter with a register-bank model
// and an independent expected-contents array; honours DBG_REGFILE_WRITE_EN.
module tb_regfile_dbg_arbiter;

    localparam int D = 4;
`ifdef DBG_REGFILE_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_dbg_halt_req, i_dbg_resume, i_dbg_req, i_dbg_we;
    logic [4:0]  i_dbg_addr;
    logic [31:0] i_dbg_wdata;
    logic        o_dbg_ack, o_dbg_halted, o_dbg_wb_conflict, o_pipe_stall;
    logic [31:0] o_dbg_rdata;
    logic [4:0]  i_id_rs, i_id_rt;
    logic        i_wb_reg_write;
    logic [4:0]  i_wb_write_register;
    logic [31:0] i_wb_write_data;
    logic [4:0]  o_rf_read_register_1, o_rf_read_register_2;
    logic        o_rf_write_enable;
    logic [4:0]  o_rf_write_register;
    logic [31:0] o_rf_write_data;
    logic [31:0] i_rf_read_data_1;

    logic [31:0] bank [32] = '{default: 32'd0};
    logic [31:0] exp_regs [32];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_dbg_arbiter #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .i_dbg_halt_req(i_dbg_halt_req), .i_dbg_resume(i_dbg_resume),
        .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we),
        .i_dbg_addr(i_dbg_addr), .i_dbg_wdata(i_dbg_wdata),
        .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata),
        .o_dbg_halted(o_dbg_halted), .o_dbg_wb_conflict(o_dbg_wb_conflict),
        .o_pipe_stall(o_pipe_stall),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
        .i_wb_reg_write(i_wb_reg_write), .i_wb_write_register(i_wb_write_register),
        .i_wb_write_data(i_wb_write_data),
        .o_rf_read_register_1(o_rf_read_register_1), .o_rf_read_register_2(o_rf_read_register_2),
        .o_rf_write_enable(o_rf_write_enable), .o_rf_write_register(o_rf_write_register),
        .o_rf_write_data(o_rf_write_data), .i_rf_read_data_1(i_rf_read_data_1)
    );

    // Register bank: $0 is hard-wired to zero.
    assign i_rf_read_data_1 = bank[o_rf_read_register_1];
    always @(posedge clk) begin
        if (o_rf_write_enable && o_rf_write_register != 5'd0)
            bank[o_rf_write_register] <= o_rf_write_data;
    end

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d, input bool_expected_commit);
    endtask

    // Halt from RUN; optionally inject a WB write and a stray resume while draining.
    task automatic halt_seq(input bit with_wb);
        i_dbg_halt_req = 1'b1;
        @(negedge clk);
        i_dbg_halt_req = 1'b0;
        for (int i = 1; i <= D; i++) begin
            chk1("drain_stall", o_pipe_stall, 1'b1);
            chk1("drain_halted", o_dbg_halted, 1'b0);
            if (i == 1) i_dbg_resume = 1'b1;
            if (i == 2) begin
                i_dbg_resume = 1'b0;
                if (with_wb) begin
                    i_wb_reg_write = 1'b1;
                    i_wb_write_register = 5'd5;
                    i_wb_write_data = 32'h0000_1234;
                    #1 chk1("drain_wb_wen", o_rf_write_enable, 1'b1);
                    exp_regs[5] = 32'h0000_1234;
                end
            end
            if (i == 3) begin
                i_wb_reg_write = 1'b0;
                if (with_wb) chk32("drain_wb_bank5", bank[5], exp_regs[5]);
            end
            @(negedge clk);
        end
        i_wb_reg_write = 1'b0;
        i_dbg_resume = 1'b0;
        chk1("halt_latency", o_dbg_halted, 1'b1);
        chk1("halt_stall", o_pipe_stall, 1'b1);
    endtask

    task automatic host_access(input string tag, input logic we, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic with_resume);
        logic eff_we;
        eff_we = we && WR_EN;
        i_dbg_req = 1'b1;
        i_dbg_we = we;
        i_dbg_addr = addr;
        i_dbg_wdata = wdata;
        i_dbg_resume = with_resume;
        @(negedge clk);
        i_dbg_resume = 1'b0;
        chk1({tag, "_access_wen"}, o_rf_write_enable, eff_we && (addr != 5'd0));
        chk1({tag, "_access_ack"}, o_dbg_ack, 1'b0);
        if (eff_we && addr != 5'd0) begin
            chk32({tag, "_wdata"}, o_rf_write_data, wdata);
            exp_regs[addr] = wdata;
        end
        @(negedge clk);
        chk1({tag, "_ack"}, o_dbg_ack, 1'b1);
        if (!eff_we) chk32({tag, "_rdata"}, o_dbg_rdata, exp_regs[addr]);
        else         chk32({tag, "_bank"}, bank[addr], exp_regs[addr]);
        i_dbg_req = 1'b0;
        @(negedge clk);
        chk1({tag, "_ack_pulse"}, o_dbg_ack, 1'b0);
        @(negedge clk);
        $display("access %s we=%0b addr=%0d wdata=%h rdata=%h", tag, we, addr, wdata, o_dbg_rdata);
    endtask

    task automatic resume_seq();
        i_dbg_resume = 1'b1;
        @(negedge clk);
        i_dbg_resume = 1'b0;
        chk1("resume_stall", o_pipe_stall, 1'b0);
        chk1("resume_halted", o_dbg_halted, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
        reset = 1'b0;
        i_dbg_halt_req = 0; i_dbg_resume = 0; i_dbg_req = 0; i_dbg_we = 0;
        i_dbg_addr = 0; i_dbg_wdata = 0; i_id_rs = 0; i_id_rt = 0;
        i_wb_reg_write = 0; i_wb_write_register = 0; i_wb_write_data = 0;
        repeat (3) @(negedge clk);
        chk1("rst_stall", o_pipe_stall, 1'b0);
        chk1("rst_halted", o_dbg_halted, 1'b0);
        chk1("rst_ack", o_dbg_ack, 1'b0);
        chk1("rst_conflict", o_dbg_wb_conflict, 1'b0);
        chk1("rst_wen", o_rf_write_enable, 1'b0);
        chk32("rst_rdata", o_dbg_rdata, 32'd0);
        reset = 1'b1;

        // RUN pass-through
        i_id_rs = 5'd3; i_id_rt = 5'd17;
        i_wb_reg_write = 1'b1; i_wb_write_register = 5'd2; i_wb_write_data = 32'h22;
        #1;
        chk32("run_rs", 32'(o_rf_read_register_1), 32'd3);
        chk32("run_rt", 32'(o_rf_read_register_2), 32'd17);
        chk1("run_wen", o_rf_write_enable, 1'b1);
        exp_regs[2] = 32'h22;
        @(negedge clk);
        i_wb_reg_write = 1'b0;
        repeat (5) @(negedge clk);
        chk32("run_bank2", bank[2], exp_regs[2]);
        chk1("run_stall", o_pipe_stall, 1'b0);

        halt_seq(1'b1);
        chk32("halted_rt", 32'(o_rf_read_register_2), 32'd17);
        host_access("wr7", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
        host_access("rd7", 1'b0, 5'd7, 32'd0, 1'b0);
        host_access("wr0", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        host_access("rd0", 1'b0, 5'd0, 32'd0, 1'b0);
        host_access("rd5", 1'b0, 5'd5, 32'd0, 1'b0);

        // WB write while halted is dropped and flagged
        i_wb_reg_write = 1'b1; i_wb_write_register = 5'd9; i_wb_write_data = 32'hAAAA;
        #1 chk1("conflict_wen", o_rf_write_enable, 1'b0);
        @(negedge clk);
        i_wb_reg_write = 1'b0;
        chk1("conflict_flag", o_dbg_wb_conflict, 1'b1);
        chk32("conflict_bank9", bank[9], exp_regs[9]);

        host_access("req_resume", 1'b0, 5'd2, 32'd0, 1'b1);
        chk1("req_resume_halted", o_dbg_halted, 1'b1);
        resume_seq();
        chk1("conflict_sticky", o_dbg_wb_conflict, 1'b1);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < int'($urandom_range(2, 6)); c++) begin
                i_wb_reg_write = 1'($urandom);
                i_wb_write_register = 5'($urandom_range(0, 7));
                i_wb_write_data = $urandom;
                if (i_wb_reg_write && i_wb_write_register != 5'd0)
                    exp_regs[i_wb_write_register] = i_wb_write_data;
                @(negedge clk);
            end
            i_wb_reg_write = 1'b0;
            halt_seq(1'b0);
            for (int a = 0; a < 4; a++)
                host_access("rand", 1'($urandom), 5'($urandom_range(0, 7)), $urandom, 1'b0);
            resume_seq();
        end
        for (int i = 0; i < 32; i++) chk32($sformatf("bank_final_%0d", i), bank[i], exp_regs[i]);

        // Reset in the middle of a host write access
        halt_seq(1'b0);
        i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd12; i_dbg_wdata = 32'h5555_AAAA;
        @(negedge clk);
        reset = 1'b0;
        #1 chk1("rst_access_wen", o_rf_write_enable, 1'b0);
        @(negedge clk);
        chk1("rst_access_ack", o_dbg_ack, 1'b0);
        chk1("rst_access_stall", o_pipe_stall, 1'b0);
        chk1("rst_access_halted", o_dbg_halted, 1'b0);
        chk1("rst_access_conflict", o_dbg_wb_conflict, 1'b0);
        chk32("rst_access_rdata", o_dbg_rdata, 32'd0);
        chk32("rst_access_bank12", bank[12], exp_regs[12]);
        reset = 1'b1;
        i_dbg_req = 1'b0;
        @(negedge clk);
        chk1("rst_access_no_ack", o_dbg_ack, 1'b0);
        chk1("rst_access_run", o_pipe_stall, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
